bcd_digit_counter: RTL and testbench

Two-digit BCD up/down event counter with a built-in tick prescaler and a start/stop/pause control FSM. It sits directly upstream of the seven-segment decoders. Each 4-bit digit output drives one decoder instance's 4-bit input. Digit values are always 0–9, so the decoders never see a non-decimal code.

---
 rtl/bcd_digit_counter.sv | 137 +++++++++++++
 tb/tb_bcd_digit_counter.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/bcd_digit_counter.sv
// Two-digit BCD up/down event counter with a tick prescaler and a
// start/stop/pause control FSM. Feeds the seven-segment decoders directly,
// so both digits are always held in the range 0-9.
module bcd_digit_counter #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       stop,
    input  logic       clear,
    input  logic       up_dn,
    input  logic       load,
    input  logic [7:0] load_val,
    output logic [3:0] digit_hi,
    output logic [3:0] digit_lo,
    output logic       running,
    output logic       wrap,
    output logic       load_err
);

    localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_RUN    = 2'd1;
    localparam logic [1:0] ST_PAUSED = 2'd2;

    logic [1:0]    state, state_nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic [3:0]    hi_nxt, lo_nxt;
    logic          wrap_nxt, err_nxt;
    logic          load_ok;
    logic [3:0]    step_hi, step_lo;
    logic          step_wrap;

    assign load_ok = load && (load_val[7:4] <= 4'd9) && (load_val[3:0] <= 4'd9);

    // Value the digits would take on a count step in the current direction
    always_comb begin
        step_hi   = digit_hi;
        step_lo   = digit_lo;
        step_wrap = 1'b0;
        if (up_dn) begin
            if (digit_lo == 4'd9) begin
                step_lo = '0;
                if (digit_hi == 4'd9) begin
                    step_hi   = '0;
                    step_wrap = 1'b1;
                end else begin
                    step_hi = digit_hi + 4'd1;
                end
            end else begin
                step_lo = digit_lo + 4'd1;
            end
        end else begin
            if (digit_lo == 4'd0) begin
                step_lo = 4'd9;
                if (digit_hi == 4'd0) begin
                    step_hi   = 4'd9;
                    step_wrap = 1'b1;
                end else begin
                    step_hi = digit_hi - 4'd1;
                end
            end else begin
                step_lo = digit_lo - 4'd1;
            end
        end
    end

    // Next-state decode; priority clear > accepted load > stop > start.
    // A rejected load only raises load_err and falls through to stop/start/step.
    always_comb begin
        state_nxt = state;
        presc_nxt = presc;
        hi_nxt    = digit_hi;
        lo_nxt    = digit_lo;
        wrap_nxt  = 1'b0;
        err_nxt   = 1'b0;
        if (clear) begin
            state_nxt = ST_IDLE;
            presc_nxt = '0;
            hi_nxt    = '0;
            lo_nxt    = '0;
        end else if (load_ok) begin
            presc_nxt = '0;
            hi_nxt    = load_val[7:4];
            lo_nxt    = load_val[3:0];
        end else begin
            err_nxt = load;
            if (stop) begin
                if (state == ST_RUN) begin
                    state_nxt = ST_PAUSED;
                end
            end else if (start && (state != ST_RUN)) begin
                // Resuming from PAUSED keeps the partial prescaler count
                state_nxt = ST_RUN;
                if (state == ST_IDLE) begin
                    presc_nxt = '0;
                end
            end else if (state == ST_RUN) begin
                if (presc == PRESC_LAST) begin
                    presc_nxt = '0;
                    hi_nxt    = step_hi;
                    lo_nxt    = step_lo;
                    wrap_nxt  = step_wrap;
                end else begin
                    presc_nxt = presc + 1'b1;
                end
            end else if (state == ST_IDLE) begin
                presc_nxt = '0;
            end
        end
    end

    // State, count and output registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            presc    <= '0;
            digit_hi <= '0;
            digit_lo <= '0;
            running  <= 1'b0;
            wrap     <= 1'b0;
            load_err <= 1'b0;
        end else begin
            state    <= state_nxt;
            presc    <= presc_nxt;
            digit_hi <= hi_nxt;
            digit_lo <= lo_nxt;
            running  <= (state_nxt == ST_RUN);
            wrap     <= wrap_nxt;
            load_err <= err_nxt;
        end
    end

endmodule

// File: tb/tb_bcd_digit_counter.sv
// Directed bench for bcd_digit_counter: main instance with TICK_DIV = 4,
// plus a TICK_DIV = 1 instance sharing the same inputs.
module tb_bcd_digit_counter;

    logic       clk = 1'b0;
    logic       rst_n, start, stop, clear, up_dn, load;
    logic [7:0] load_val;
    logic [3:0] digit_hi, digit_lo, d1_hi, d1_lo;
    logic       running, wrap, load_err, d1_running, d1_wrap, d1_load_err;

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    always #5 clk = ~clk;

    bcd_digit_counter #(.TICK_DIV(4)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .digit_hi(digit_hi), .digit_lo(digit_lo), .running(running),
        .wrap(wrap), .load_err(load_err)
    );

    bcd_digit_counter #(.TICK_DIV(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .clear(clear),
        .up_dn(up_dn), .load(load), .load_val(load_val),
        .digit_hi(d1_hi), .digit_lo(d1_lo), .running(d1_running),
        .wrap(d1_wrap), .load_err(d1_load_err)
    );

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock edge; inputs change and outputs are sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic cycles(input int unsigned n);
        for (int unsigned i = 0; i < n; i++) tick();
    endtask

    function automatic logic [7:0] digits();
        return {digit_hi, digit_lo};
    endfunction

    task automatic do_clear();
        clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic do_load(input logic [7:0] v);
        load_val = v; load = 1'b1; tick(); load = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; clear = 1'b0;
        up_dn = 1'b1; load = 1'b0; load_val = 8'h00;

        // Reset state
        cycles(3);
        check("rst_digits", digits(), 8'h00);
        check("rst_flags", {5'd0, running, wrap, load_err}, 8'h00);
        check("rst_d1_digits", {d1_hi, d1_lo}, 8'h00);
        rst_n = 1'b1;
        tick();

        // First step: start at edge N, steps at N+4, N+8 (TICK_DIV=1 steps every edge)
        do_start();
        check("start_running", {7'd0, running}, 8'h01);
        check("start_digits", digits(), 8'h00);
        tick();
        check("d1_step1", {d1_hi, d1_lo}, 8'h01);
        tick();
        check("d1_step2", {d1_hi, d1_lo}, 8'h02);
        tick();
        check("pre_step1", digits(), 8'h00);
        tick();
        check("step1", digits(), 8'h01);
        cycles(3);
        check("pre_step2", digits(), 8'h01);
        tick();
        check("step2", digits(), 8'h02);

        // Up wrap 98 -> 99 -> 00 -> 01
        do_clear();
        check("clear_running", {7'd0, running}, 8'h00);
        do_load(8'h98);
        check("load98_idle", {digit_hi, digit_lo}, 8'h98);
        do_start();
        cycles(4);
        check("up_99", digits(), 8'h99);
        check("up_99_nowrap", {7'd0, wrap}, 8'h00);
        cycles(4);
        check("up_wrap_digits", digits(), 8'h00);
        check("up_wrap_pulse", {7'd0, wrap}, 8'h01);
        tick();
        check("up_wrap_end", {7'd0, wrap}, 8'h00);
        cycles(3);
        check("up_after_wrap", digits(), 8'h01);

        // Down borrow 10 -> 09, then 00 -> 99 with wrap
        do_clear();
        up_dn = 1'b0;
        do_load(8'h10);
        do_start();
        cycles(4);
        check("dn_borrow", digits(), 8'h09);
        check("dn_borrow_nowrap", {7'd0, wrap}, 8'h00);
        do_clear();
        do_start();
        cycles(4);
        check("dn_wrap_digits", digits(), 8'h99);
        check("dn_wrap_pulse", {7'd0, wrap}, 8'h01);
        tick();
        check("dn_wrap_end", {7'd0, wrap}, 8'h00);

        // Pause with prescaler = 2, resume lands 2 edges later
        do_clear();
        up_dn = 1'b1;
        do_start();
        cycles(2);
        stop = 1'b1; tick(); stop = 1'b0;
        check("stop_running", {7'd0, running}, 8'h00);
        cycles(20);
        check("paused_digits", digits(), 8'h00);
        do_start();
        check("resume_running", {7'd0, running}, 8'h01);
        tick();
        check("resume_pre", digits(), 8'h00);
        tick();
        check("resume_step", digits(), 8'h01);

        // start+stop together: RUN -> PAUSED, PAUSED stays
        start = 1'b1; stop = 1'b1; tick();
        check("ss_run_paused", {7'd0, running}, 8'h00);
        tick();
        start = 1'b0; stop = 1'b0;
        check("ss_stay_paused", {7'd0, running}, 8'h00);
        check("ss_digits", digits(), 8'h01);

        // Rejected and accepted loads
        do_load(8'h3A);
        check("bad_load_err", {7'd0, load_err}, 8'h01);
        check("bad_load_digits", digits(), 8'h01);
        tick();
        check("bad_load_err_end", {7'd0, load_err}, 8'h00);
        check("bad_load_state", {7'd0, running}, 8'h00);
        do_start();
        do_load(8'h47);
        check("load47_digits", digits(), 8'h47);
        check("load47_running", {7'd0, running}, 8'h01);
        cycles(3);
        check("load47_pre", digits(), 8'h47);
        tick();
        check("load47_step", digits(), 8'h48);

        // clear + load + stop in RUN -> IDLE, 00
        clear = 1'b1; load = 1'b1; load_val = 8'h55; stop = 1'b1;
        tick();
        clear = 1'b0; load = 1'b0; stop = 1'b0;
        check("prio_digits", digits(), 8'h00);
        check("prio_flags", {5'd0, running, wrap, load_err}, 8'h00);

        // Reset on a step edge overrides the step
        do_load(8'h98);
        do_start();
        cycles(3);
        rst_n = 1'b0; tick();
        check("rst_step_digits", digits(), 8'h00);
        check("rst_step_flags", {5'd0, running, wrap, load_err}, 8'h00);
        rst_n = 1'b1;
        cycles(5);
        check("post_rst_idle", {3'd0, running, digit_lo}, 8'h00);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
